// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit: states, opcodes, ALU ops, PC sources.
// Build option MC_CTRL_HALT_EN adds the sHALT state (opcode 111111) and widens the state to 4 bits.
package mc_ctrl_pkg;

  localparam int OPCODE_WIDTH = 6;
  localparam int ALUOP_WIDTH  = 3;

`ifdef MC_CTRL_HALT_EN
  localparam int STATE_W = 4;
`else
  localparam int STATE_W = 3;
`endif

  typedef enum logic [STATE_W-1:0] {
    S_IF     = STATE_W'(0),
    S_ID     = STATE_W'(1),
    S_EXE_AL = STATE_W'(2),
    S_EXE_BR = STATE_W'(3),
    S_EXE_LS = STATE_W'(4),
    S_MEM    = STATE_W'(5),
    S_WB_AL  = STATE_W'(6),
    S_WB_LD  = STATE_W'(7)
`ifdef MC_CTRL_HALT_EN
    ,
    S_HALT   = STATE_W'(8)
`endif
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = 6'b000000;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB   = 6'b000001;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDIU = 6'b000010;
  localparam logic [OPCODE_WIDTH-1:0] OP_AND   = 6'b010000;
  localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = 6'b010001;
  localparam logic [OPCODE_WIDTH-1:0] OP_ORI   = 6'b010010;
  localparam logic [OPCODE_WIDTH-1:0] OP_XORI  = 6'b010011;
  localparam logic [OPCODE_WIDTH-1:0] OP_SLL   = 6'b011000;
  localparam logic [OPCODE_WIDTH-1:0] OP_SLTI  = 6'b100110;
  localparam logic [OPCODE_WIDTH-1:0] OP_SLT   = 6'b100111;
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'b110000;
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'b110001;
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'b110100;
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE   = 6'b110101;
  localparam logic [OPCODE_WIDTH-1:0] OP_BLTZ  = 6'b110110;
  localparam logic [OPCODE_WIDTH-1:0] OP_J     = 6'b111000;
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = 6'b111111;

  localparam logic [ALUOP_WIDTH-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUOP_WIDTH-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUOP_WIDTH-1:0] ALU_LTU = 3'b010;
  localparam logic [ALUOP_WIDTH-1:0] ALU_LTS = 3'b011;
  localparam logic [ALUOP_WIDTH-1:0] ALU_SLL = 3'b100;
  localparam logic [ALUOP_WIDTH-1:0] ALU_OR  = 3'b101;
  localparam logic [ALUOP_WIDTH-1:0] ALU_AND = 3'b110;
  localparam logic [ALUOP_WIDTH-1:0] ALU_XOR = 3'b111;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    CL_NOP,
    CL_AL,
    CL_BR,
    CL_LS,
    CL_J,
    CL_HALT
  } iclass_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode decode: instruction class plus the EXE/WB selects for ALU-type instructions.
// With MC_CTRL_HALT_EN, opcode 111111 decodes as CL_HALT; otherwise it falls to NOP.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output iclass_t                 iclass,
  output logic [ALUOP_WIDTH-1:0]  aluop,
  output logic                    alusrca,
  output logic                    alusrcb,
  output logic                    extsel,
  output logic                    regdst
);

  always_comb begin
    iclass  = CL_NOP;
    aluop   = ALU_ADD;
    alusrca = 1'b0;
    alusrcb = 1'b0;
    extsel  = 1'b1;
    regdst  = 1'b0;
    case (opcode)
      OP_ADD:   begin iclass = CL_AL; regdst = 1'b1; end
      OP_SUB:   begin iclass = CL_AL; aluop = ALU_SUB; regdst = 1'b1; end
      OP_ADDIU: begin iclass = CL_AL; alusrcb = 1'b1; end
      OP_AND:   begin iclass = CL_AL; aluop = ALU_AND; regdst = 1'b1; end
      OP_ANDI:  begin iclass = CL_AL; aluop = ALU_AND; alusrcb = 1'b1; extsel = 1'b0; end
      OP_ORI:   begin iclass = CL_AL; aluop = ALU_OR;  alusrcb = 1'b1; extsel = 1'b0; end
      OP_XORI:  begin iclass = CL_AL; aluop = ALU_XOR; alusrcb = 1'b1; extsel = 1'b0; end
      // sll shifts ReadData2 by the sa field, so operand A comes from sa
      OP_SLL:   begin iclass = CL_AL; aluop = ALU_SLL; alusrca = 1'b1; regdst = 1'b1; end
      OP_SLTI:  begin iclass = CL_AL; aluop = ALU_LTS; alusrcb = 1'b1; end
      OP_SLT:   begin iclass = CL_AL; aluop = ALU_LTS; regdst = 1'b1; end
      OP_SW, OP_LW:            iclass = CL_LS;
      OP_BEQ, OP_BNE, OP_BLTZ: iclass = CL_BR;
      OP_J:                    iclass = CL_J;
`ifdef MC_CTRL_HALT_EN
      OP_HALT:                 iclass = CL_HALT;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM: steps each instruction through IF/ID/EXE/MEM/WB and gates control by state.
// Build option MC_CTRL_HALT_EN adds a sticky sHALT state entered from sID on opcode 111111.
//
// state    | meaning
// sIF      | fetch, IR load
// sID      | decode; j and NOP finish here
// sEXE_AL  | ALU-type execute
// sEXE_BR  | branch compare, PC update
// sEXE_LS  | load/store address add
// sMEM     | data memory access; sw finishes here
// sWB_AL   | ALU result write-back
// sWB_LD   | load data write-back
// sHALT    | idle until Reset (MC_CTRL_HALT_EN only)
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OPCODE_W = OPCODE_WIDTH,
  parameter int ALUOP_W  = ALUOP_WIDTH
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic               zero,
  input  logic               sign,
  output logic               PCWre,
  output logic               IRWre,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               ExtSel,
  output logic               RegWre,
  output logic               RegDst,
  output logic               DBDataSrc,
  output logic               mRD,
  output logic               mWR,
  output logic [1:0]         PCSrc
);

  state_t                  state;
  iclass_t                 dec_class;
  logic [ALUOP_WIDTH-1:0]  dec_aluop;
  logic                    dec_srca;
  logic                    dec_srcb;
  logic                    dec_ext;
  logic                    dec_regdst;
  logic                    br_taken;

  mc_ctrl_decode u_decode (
    .opcode  (Opcode),
    .iclass  (dec_class),
    .aluop   (dec_aluop),
    .alusrca (dec_srca),
    .alusrcb (dec_srcb),
    .extsel  (dec_ext),
    .regdst  (dec_regdst)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= S_IF;
    end else begin
      case (state)
        S_IF: state <= S_ID;
        S_ID: begin
          case (dec_class)
            CL_AL:   state <= S_EXE_AL;
            CL_BR:   state <= S_EXE_BR;
            CL_LS:   state <= S_EXE_LS;
`ifdef MC_CTRL_HALT_EN
            CL_HALT: state <= S_HALT;
`endif
            default: state <= S_IF;
          endcase
        end
        S_EXE_AL: state <= S_WB_AL;
        S_EXE_LS: state <= S_MEM;
        S_MEM:    state <= (Opcode == OP_SW) ? S_IF : S_WB_LD;
`ifdef MC_CTRL_HALT_EN
        S_HALT:   state <= S_HALT;
`endif
        default:  state <= S_IF;
      endcase
    end
  end

  // ALU flags are live in sEXE_BR, so the branch decision is not registered
  always_comb begin
    case (Opcode)
      OP_BEQ:  br_taken = zero;
      OP_BNE:  br_taken = ~zero;
      OP_BLTZ: br_taken = sign;
      default: br_taken = 1'b0;
    endcase
  end

  // Reset masks everything so an aborted instruction cannot leak a write
  always_comb begin
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = ALU_ADD;
    ExtSel    = 1'b0;
    RegWre    = 1'b0;
    RegDst    = 1'b0;
    DBDataSrc = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    PCSrc     = PC_NEXT;
    if (!Reset) begin
      case (state)
        S_IF: IRWre = 1'b1;
        S_ID: begin
          if (dec_class == CL_J) begin
            PCWre = 1'b1;
            PCSrc = PC_JUMP;
          end else if (dec_class == CL_NOP) begin
            PCWre = 1'b1;
          end
        end
        S_EXE_AL: begin
          ALUOp   = dec_aluop;
          ALUSrcA = dec_srca;
          ALUSrcB = dec_srcb;
          ExtSel  = dec_ext;
        end
        S_WB_AL: begin
          RegWre = 1'b1;
          RegDst = dec_regdst;
          PCWre  = 1'b1;
        end
        S_EXE_BR: begin
          ALUOp = ALU_SUB;
          PCWre = 1'b1;
          PCSrc = br_taken ? PC_BRANCH : PC_NEXT;
        end
        S_EXE_LS: begin
          ALUSrcB = 1'b1;
          ExtSel  = 1'b1;
        end
        S_MEM: begin
          if (Opcode == OP_SW) begin
            mWR   = 1'b1;
            PCWre = 1'b1;
          end else begin
            mRD = 1'b1;
          end
        end
        S_WB_LD: begin
          RegWre    = 1'b1;
          DBDataSrc = 1'b1;
          PCWre     = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm; expected control vectors are hand-computed per state.
// Follows MC_CTRL_HALT_EN to pick the expectation for opcode 111111.
module tb_mc_control_fsm;

  logic       CLK;
  logic       Reset;
  logic [5:0] Opcode;
  logic       zero;
  logic       sign;
  logic       PCWre, IRWre, ALUSrcA, ALUSrcB, ExtSel, RegWre, RegDst, DBDataSrc, mRD, mWR;
  logic [2:0] ALUOp;
  logic [1:0] PCSrc;

  int total = 0;
  int bad   = 0;

  mc_control_fsm dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .zero(zero), .sign(sign),
    .PCWre(PCWre), .IRWre(IRWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ExtSel(ExtSel), .RegWre(RegWre), .RegDst(RegDst), .DBDataSrc(DBDataSrc),
    .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {PCWre, IRWre, ALUSrcA, ALUSrcB, ALUOp[2:0], ExtSel, RegWre, RegDst, DBDataSrc, mRD, mWR, PCSrc[1:0]}
  logic [14:0] outs;
  assign outs = {PCWre, IRWre, ALUSrcA, ALUSrcB, ALUOp, ExtSel, RegWre, RegDst, DBDataSrc, mRD, mWR, PCSrc};

  localparam logic [14:0] PCW = 15'h4000, IRW = 15'h2000, SA = 15'h1000, SB = 15'h0800;
  localparam logic [14:0] EXT = 15'h0080, RW = 15'h0040, RD = 15'h0020, DB = 15'h0010;
  localparam logic [14:0] MRD = 15'h0008, MWR = 15'h0004, PCBR = 15'h0001, PCJ = 15'h0002;
  localparam logic [14:0] A_SUB = 15'h0100, A_LTS = 15'h0300, A_SLL = 15'h0400;
  localparam logic [14:0] A_OR = 15'h0500, A_AND = 15'h0600, A_XOR = 15'h0700;

  task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input string tag, input logic [14:0] exp);
    chk(tag, outs, exp);
    tick();
  endtask

  initial begin
    Reset  = 1'b1;
    Opcode = 6'b000000;
    zero   = 1'b0;
    sign   = 1'b0;
    tick();
    chk("rst_c1", outs, 15'h0);
    tick();
    chk("rst_c2", outs, 15'h0);
    Reset = 1'b0;
    #1;

    // add: IF ID EXE WB
    step("add_if", IRW);
    step("add_id", 15'h0);
    step("add_exe", EXT);
    step("add_wb", PCW | RW | RD);

    // lw
    Opcode = 6'b110001;
    step("lw_if", IRW);
    step("lw_id", 15'h0);
    step("lw_exe", SB | EXT);
    step("lw_mem", MRD);
    step("lw_wb", PCW | RW | DB);

    // branches
    Opcode = 6'b110100; zero = 1'b1;
    step("beq_t_if", IRW);
    step("beq_t_id", 15'h0);
    step("beq_t_exe", PCW | A_SUB | PCBR);
    zero = 1'b0;
    step("beq_n_if", IRW);
    step("beq_n_id", 15'h0);
    step("beq_n_exe", PCW | A_SUB);
    Opcode = 6'b110101;
    step("bne_t_if", IRW);
    step("bne_t_id", 15'h0);
    step("bne_t_exe", PCW | A_SUB | PCBR);
    Opcode = 6'b110110; sign = 1'b1; zero = 1'b1;
    step("bltz_t_if", IRW);
    step("bltz_t_id", 15'h0);
    step("bltz_t_exe", PCW | A_SUB | PCBR);
    sign = 1'b0;
    step("bltz_n_if", IRW);
    step("bltz_n_id", 15'h0);
    step("bltz_n_exe", PCW | A_SUB);

    // ALU variants
    Opcode = 6'b011000;
    step("sll_if", IRW);
    step("sll_id", 15'h0);
    step("sll_exe", SA | A_SLL | EXT);
    step("sll_wb", PCW | RW | RD);
    Opcode = 6'b010010;
    step("ori_if", IRW);
    step("ori_id", 15'h0);
    step("ori_exe", SB | A_OR);
    step("ori_wb", PCW | RW);
    Opcode = 6'b100110;
    step("slti_if", IRW);
    step("slti_id", 15'h0);
    step("slti_exe", SB | A_LTS | EXT);
    step("slti_wb", PCW | RW);
    Opcode = 6'b010001;
    step("andi_if", IRW);
    step("andi_id", 15'h0);
    step("andi_exe", SB | A_AND);
    step("andi_wb", PCW | RW);
    Opcode = 6'b010011;
    step("xori_if", IRW);
    step("xori_id", 15'h0);
    step("xori_exe", SB | A_XOR);
    step("xori_wb", PCW | RW);
    Opcode = 6'b000001;
    step("sub_if", IRW);
    step("sub_id", 15'h0);
    step("sub_exe", A_SUB | EXT);
    step("sub_wb", PCW | RW | RD);

    // sw
    Opcode = 6'b110000;
    step("sw_if", IRW);
    step("sw_id", 15'h0);
    step("sw_exe", SB | EXT);
    step("sw_mem", PCW | MWR);

    // j and unknown
    Opcode = 6'b111000;
    step("j_if", IRW);
    step("j_id", PCW | PCJ);
    Opcode = 6'b101010;
    step("nop_if", IRW);
    step("nop_id", PCW);

    // reset landing in sMEM of sw
    Opcode = 6'b110000;
    step("swr_if", IRW);
    step("swr_id", 15'h0);
    step("swr_exe", SB | EXT);
    chk("swr_mem", outs, PCW | MWR);
    Reset = 1'b1;
    tick();
    chk("swr_rst", outs, 15'h0);
    Reset = 1'b0;
    #1;
    chk("swr_after_if", outs, IRW);
    tick();
    chk("swr_after_id", outs, 15'h0);
    tick();
    chk("swr_after_exe", outs, SB | EXT);
    tick();
    chk("swr_after_mem", outs, PCW | MWR);
    tick();

    // opcode 111111
    Opcode = 6'b111111;
    step("ff_if", IRW);
`ifdef MC_CTRL_HALT_EN
    step("halt_id", 15'h0);
    for (int i = 0; i < 20; i++) step("halt_hold", 15'h0);
    Reset = 1'b1;
    tick();
    chk("halt_rst", outs, 15'h0);
    Reset = 1'b0;
    #1;
    chk("halt_exit_if", outs, IRW);
`else
    step("ff_nop_id", PCW);
    chk("ff_nop_next_if", outs, IRW);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
